// File: rtl/reconfig_pkg.sv
// Shared constants and FSM state type for the reconfigurable multiplier/divider pair.
package reconfig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_K1    = 3;
  localparam int unsigned DEF_K0    = 5;

endpackage

// File: rtl/reconfig_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
// Assumes rem_in < d, so the trial value never exceeds 2*d-1.
module reconfig_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    trial   = {rem_in, dvd_bit};
    diff    = trial - {1'b0, d};
    // A borrow out of the top bit means trial < d.
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/reconfig_div_seq.sv
// Iterative restoring divider recovering x from y = x*K1 or x*K0, one quotient bit per clock.
// Optional RECONFIG_DIV_ROUND_EN: round the quotient half-up (saturating); remainder stays truncated.
module reconfig_div_seq
  import reconfig_pkg::*;
#(
  parameter int unsigned       WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  K1    = WIDTH'(DEF_K1),
  parameter logic [WIDTH-1:0]  K0    = WIDTH'(DEF_K0)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y,
  input  logic             s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             exact
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (K0 == '0 || K1 == '0) begin : g_bad_divisor
    $error("reconfig_div_seq: K0 and K1 must both be nonzero");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] dvd_q,   dvd_d;
  logic [WIDTH-1:0] d_q,     d_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic             rdy_q,   rdy_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  reconfig_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[cnt_q]),
    .d       (d_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = (state_q == IDLE) && rdy_q;
  assign out_valid = (state_q == DONE);
  assign q         = out_valid ? quo_q : '0;
  assign r         = out_valid ? rem_q : '0;
  assign exact     = out_valid && (rem_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    d_d     = d_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rdy_d   = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          dvd_d   = y;
          d_d     = s ? K1 : K0;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
`ifdef RECONFIG_DIV_ROUND_EN
          if (({step_rem, 1'b0} >= {1'b0, d_q}) && (quo_d != '1)) begin
            quo_d = quo_d + WIDTH'(1);
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_reconfig_div_seq.sv
// Scoreboard bench for reconfig_div_seq: stimulus pushes model results, a negedge monitor pops and compares.
module tb_reconfig_div_seq;

  localparam int W      = 32;
  localparam int LAT    = 33;
  localparam int TB_K1  = 3;
  localparam int TB_K0  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  y = '0;
  logic          s = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  q;
  logic [W-1:0]  r;
  logic          exact;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ex;
    int           hs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic prev_ov = 1'b0;

  reconfig_div_seq #(.WIDTH(W), .K1(32'd3), .K0(32'd5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .exact     (exact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: plain integer division by the selected constant.
  function automatic exp_t model(input logic [W-1:0] yy, input logic ss, input int hs);
    exp_t e;
    longint unsigned dv, qv, rv;
    dv = ss ? longint'(TB_K1) : longint'(TB_K0);
    qv = longint'(yy) / dv;
    rv = longint'(yy) % dv;
`ifdef RECONFIG_DIV_ROUND_EN
    if ((2 * rv >= dv) && (qv != 64'hFFFF_FFFF)) qv = qv + 1;
`endif
    e.q  = qv[W-1:0];
    e.r  = rv[W-1:0];
    e.ex = (rv == 0);
    e.hs = hs;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] yy, input logic ss);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    y = yy;
    s = ss;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        fail_now("send_timeout");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    sb.push_back(model(yy, ss, cyc));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) fail_now("drain_timeout");
  endtask

  // Monitor: every cycle out_valid is high the held result must match the queue head.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          fail_now("spurious_out_valid");
        end else begin
          if (!prev_ov) chk("latency", 64'(cyc - sb[0].hs), 64'(LAT));
          chk("q", 64'(q), 64'(sb[0].q));
          chk("r", 64'(r), 64'(sb[0].r));
          chk("exact", 64'(exact), 64'(sb[0].ex));
          chk("in_ready_busy", 64'(in_ready), 64'd0);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_exact", 64'(exact), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Directed vectors, including rounding pair and boundaries
    send(32'd3, 1'b1);
    send(32'd5, 1'b0);
    send(32'd15, 1'b0);
    send(32'd11, 1'b1);
    send(32'd10, 1'b1);
    send(32'hFFFF_FFFF, 1'b1);
    send(32'h0, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    drain();

    // Back-pressure: hold the result while in_valid pulses are ignored
    out_ready = 1'b0;
    send(32'd301, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("stall_wait_timeout");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0);
      y = $urandom;
      s = $urandom_range(0, 1);
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (40) @(negedge clk);

    // Randomized round trips, including products of the divisors
    for (int i = 0; i < 120; i++) begin
      logic [W-1:0] yy;
      logic         ss;
      ss = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       yy = $urandom * (ss ? 32'd3 : 32'd5);
        1:       yy = 32'($urandom_range(0, 20));
        default: yy = $urandom;
      endcase
      send(yy, ss);
    end
    drain();

    // Reset in the middle of a calculation discards it
    send(32'd1000, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_q", 64'(q), 64'd0);
    chk("midrst_r", 64'(r), 64'd0);
    chk("midrst_exact", 64'(exact), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_midrst", 64'(in_ready), 64'd1);
    send(32'd9, 1'b1);
    drain();
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
